mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store data-bus engine for the multi-cycle reference CPU. It is entered when the address-check stage has produced a validated memory request (effective address, size, byte strobe, lane-replicated store data) and dispatched to the load or store state. It drives one transaction on the data bus, waits for the response, then extracts and sign- or zero-extends the loaded lane. It reports completion to the control FSM, which writes `rdata` back to `rt` for loads.

## Interface
Parameters:
- `TIMEOUT`, default 1024: max cycles from bus request to `data_ok` before `err` is raised; 0 disables the check.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  accept a request this cycle; ignored unless `busy`=0.
- `op`  in  3  access kind: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW.
- `addr`  in  32  effective address; already alignment-checked upstream.
- `size`  in  msize_t  MSIZE1/2/4.
- `strobe`  in  4  byte write strobe; all zero for loads.
- `wdata`  in  32  store data, already replicated across lanes.
- `dreq`  out  dbus_req_t  {valid, addr, size, strobe, data} to the data bus.
- `dresp`  in  dbus_resp_t  {addr_ok, data_ok, data} from the data bus.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  timeout flag; valid only with `done`.
- `rdata`  out  32  extended load result; valid with `done`, held until the next accepted `start`; 0 for stores.

## Operation
- On `start` in IDLE, latch `op`, `addr`, `size`, `strobe` and `wdata` into request registers. Input changes afterwards have no effect.
- FSM states:
  - IDLE → ADDR on `start`.
  - ADDR: `dreq.valid`=1 with the latched fields.
    - `addr_ok` & `data_ok` → DONE.
    - `addr_ok` only → DATA.
  - DATA: `dreq.valid`=0; wait for `data_ok` → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- `data_ok` in the same cycle as `addr_ok` is legal and must be captured.
- Load extraction:
  - Shift: lane = `dresp.data >> {addr[1:0], 3'b000}`.
  - LB sign-extends lane[7:0]; LBU zero-extends lane[7:0].
  - LH sign-extends lane[15:0]; LHU zero-extends lane[15:0].
  - LW passes the data through.
- `rdata` is registered on the `data_ok` cycle. Stores register 0.
- Timeout counter:
  - Clears on `start`; increments each cycle in ADDR or DATA.
  - If it reaches `TIMEOUT` (nonzero) without `data_ok`: go to DONE with `err`=1 and `rdata`=0, and drop `valid`.
  - Any `data_ok` arriving after that is ignored.
- `dresp` in IDLE or DONE (stray `data_ok`) is ignored.
- `start` while `busy` is ignored; no queuing.

## Timing
- Reset values: state IDLE, `dreq` all zero, `busy`=0, `done`=0, `err`=0, `rdata`=0, counter 0.
- `reset` mid-transaction: IDLE on the next edge and `dreq.valid`=0 the next cycle. No `done` is produced for the aborted access.
- Cycle numbering (minimum latency): `start` sampled at edge of cycle 0, `dreq.valid` high in cycle 1, and with both oks in cycle 1, `done` high in cycle 2.
- Each extra cycle before `addr_ok` or `data_ok` adds one cycle. `dreq` fields stay stable while `valid` is high.
- `done` to the next accepted `start`: `start` in the `done` cycle is not accepted (still `busy`). It is accepted the cycle after.

## Test plan
- LB at `addr`=0x1003, bus data 0x80_00_00_00, oks in cycle 1 → `done` in cycle 2, `rdata`=0xFFFFFF80; the same access with LBU → 0x00000080.
- LH at `addr`=0x2002, data 0x8001_1234, `addr_ok` cycle 1, `data_ok` cycle 4 → `valid` only in cycle 1, `done` cycle 5, `rdata`=0xFFFF8001.
- SW at 0x3000, `strobe`=0xF, `wdata`=0xDEADBEEF, `addr_ok` withheld until cycle 3 → `dreq` held stable cycles 1–3, `done` cycle 4 (`data_ok` in cycle 3), `rdata`=0.
- `TIMEOUT`=8, no response → `done`=1 and `err`=1 in cycle 9, `valid` dropped, a later `data_ok` ignored, the next `start` works normally.
- `reset` asserted in DATA state, then a stray `data_ok` → no `done`, all outputs at reset values. Also: `start` pulsed while `busy` → ignored, the original request completes unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store data-bus engine. Holds one request, drives it onto the
// data bus, waits for the response, and sign/zero-extends the loaded lane.
// Bus handshake: dreq.valid is held with stable fields until dresp.addr_ok is seen;
// dresp.data_ok (same cycle as addr_ok or later) carries the read data and ends the access.
package mem_access_pkg;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] addr;
      msize_t      size;
      logic [3:0]  strobe;
      logic [31:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [31:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_DONE = 2'd3
   } mau_state_t;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LBU = 3'd1;
   localparam logic [2:0] OP_LH  = 3'd2;
   localparam logic [2:0] OP_LHU = 3'd3;
   localparam logic [2:0] OP_LW  = 3'd4;
   localparam logic [2:0] OP_SB  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

endpackage

module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  msize_t      size,
   input  logic [3:0]  strobe,
   input  logic [31:0] wdata,
   output dbus_req_t   dreq,
   input  dbus_resp_t  dresp,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output mau_state_t  state_o
);

   localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

   mau_state_t  state_q;
   logic [2:0]  op_q;
   logic [31:0] cnt_q, cnt_d;
   dbus_req_t   dreq_q;
   logic        busy_q, done_q, err_q;
   logic [31:0] rdata_q;
   logic [31:0] lane;
   logic [31:0] load_ext;
   logic        timeout_hit;

   // Lane extraction, extension of the returned word, and timeout detection
   always_comb begin
      lane        = dresp.data >> {dreq_q.addr[1:0], 3'b000};
      load_ext    = '0;
      case (op_q)
         OP_LB:   load_ext = {{24{lane[7]}}, lane[7:0]};
         OP_LBU:  load_ext = {24'b0, lane[7:0]};
         OP_LH:   load_ext = {{16{lane[15]}}, lane[15:0]};
         OP_LHU:  load_ext = {16'b0, lane[15:0]};
         OP_LW:   load_ext = lane;
         default: load_ext = '0;  // stores return zero
      endcase
      cnt_d       = cnt_q + 32'd1;
      timeout_hit = (TIMEOUT_W != 32'd0) && (cnt_d == TIMEOUT_W);
   end

   // Access FSM with registered bus request and completion outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         dreq_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (start) begin
                  op_q    <= op;
                  cnt_q   <= '0;
                  dreq_q  <= '{valid: 1'b1, addr: addr, size: size, strobe: strobe, data: wdata};
                  busy_q  <= 1'b1;
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: begin
               cnt_q <= cnt_d;
               if (dresp.addr_ok && dresp.data_ok) begin
                  dreq_q.valid <= 1'b0;
                  rdata_q      <= load_ext;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else if (timeout_hit) begin
                  dreq_q.valid <= 1'b0;
                  rdata_q      <= '0;
                  err_q        <= 1'b1;
                  done_q       <= 1'b1;
                  state_q      <= S_DONE;
               end else if (dresp.addr_ok) begin
                  dreq_q.valid <= 1'b0;
                  state_q      <= S_DATA;
               end
            end
            S_DATA: begin
               cnt_q <= cnt_d;
               if (dresp.data_ok) begin
                  rdata_q <= load_ext;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else if (timeout_hit) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               err_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dreq    = dreq_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed transactions with a per-cycle timeline model
// derived from the bus response schedule, plus literal result values.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] addr = '0;
  msize_t      size = MSIZE1;
  logic [3:0]  strobe = '0;
  logic [31:0] wdata = '0;
  dbus_req_t   dreq;
  dbus_resp_t  dresp = '0;
  logic        busy, done, err;
  logic [31:0] rdata;
  mau_state_t  state_o;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .addr(addr), .size(size),
    .strobe(strobe), .wdata(wdata), .dreq(dreq), .dresp(dresp), .busy(busy),
    .done(done), .err(err), .rdata(rdata), .state_o(state_o)
  );

  // clock
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // per-cycle expectations, written by the driver just after each rising edge
  logic        chk_en = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_valid = 1'b0, e_err = 1'b0;
  logic        e_zero = 1'b0, e_hold = 1'b0, e_lit_en = 1'b0;
  logic [31:0] e_hold_val = '0, e_lit = '0;
  logic [31:0] e_addr = '0, e_data = '0;
  logic [3:0]  e_strobe = '0;
  msize_t      e_size = MSIZE1;
  logic [31:0] prev_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // load result from the access rules, in plain arithmetic
  function automatic logic [31:0] model_ext(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] d);
    logic [31:0] v;
    v = d >> (8 * a[1:0]);
    case (o)
      OP_LB:   begin v = v % 256;   if (v >= 128)   v = v - 32'd256;   end
      OP_LBU:  v = v % 256;
      OP_LH:   begin v = v % 65536; if (v >= 32768) v = v - 32'd65536; end
      OP_LHU:  v = v % 65536;
      OP_LW:   v = d;
      default: v = 0;
    endcase
    return v;
  endfunction

  // scoreboard / compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("valid", 32'(dreq.valid), 32'(e_valid));
      if (e_valid) begin
        chk("dreq_addr", dreq.addr, e_addr);
        chk("dreq_size", 32'(dreq.size), 32'(e_size));
        chk("dreq_strobe", 32'(dreq.strobe), 32'(e_strobe));
        chk("dreq_data", dreq.data, e_data);
      end
      if (e_done) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL rdata_queue: got empty want entry at %0t", $time);
        end else begin
          chk("rdata", rdata, exp_q.pop_front());
        end
        chk("err", 32'(err), 32'(e_err));
        if (e_lit_en) chk("rdata_literal", rdata, e_lit);
      end
      if (e_hold) chk("rdata_hold", rdata, e_hold_val);
      if (e_zero) begin
        chk("dreq_zero", 32'(dreq != '0), 32'd0);
        chk("rdata_zero", rdata, 32'd0);
        chk("err_zero", 32'(err), 32'd0);
        chk("state_idle", 32'(state_o), 32'(S_IDLE));
      end
    end
  end

  // One access: start in cycle 0, addr_ok in cycle ac, data_ok in cycle dc.
  // rst_at >= 0 asserts reset during that cycle to abort the access.
  task automatic run_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] bd, input int ac, input int dc,
                         input logic [31:0] lit, input bit poke, input int rst_at);
    bit          abort, is_st, x_err;
    msize_t      sz;
    logic [3:0]  sb;
    logic [31:0] rd;
    int          done_c, va_end, last;
    abort  = (rst_at >= 0);
    is_st  = (o >= OP_SB);
    sz     = (o == OP_LB || o == OP_LBU || o == OP_SB) ? MSIZE1 :
             (o == OP_LH || o == OP_LHU || o == OP_SH) ? MSIZE2 : MSIZE4;
    sb     = (o == OP_SB) ? (4'b0001 << a[1:0]) : (o == OP_SH) ? (4'b0011 << a[1:0]) :
             (o == OP_SW) ? 4'hF : 4'h0;
    x_err  = (dc > TO);
    done_c = x_err ? TO + 1 : dc + 1;
    va_end = (ac < TO) ? ac : TO;
    rd     = (x_err || is_st) ? 32'd0 : model_ext(o, a, bd);
    if (!abort) exp_q.push_back(rd);
    last   = abort ? rst_at + 4 : done_c + 1;
    if (ac > last) last = ac;
    if (dc > last) last = dc;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk); #1;
      reset = abort && (k == rst_at);
      start = (k == 0) || (poke && k == 2) || (!abort && k == done_c);
      if (k == 0) begin
        op = o; addr = a; size = sz; strobe = sb; wdata = wd;
      end else begin
        op = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
        strobe = 4'($urandom_range(0, 15)); size = msize_t'($urandom_range(0, 2));
      end
      dresp.addr_ok = (k == ac);
      dresp.data_ok = (k == dc);
      dresp.data    = (k == dc) ? bd : $urandom;
      e_busy   = (k >= 1) && (k <= (abort ? rst_at : done_c));
      e_done   = !abort && (k == done_c);
      e_valid  = (k >= 1) && (k <= va_end) && (!abort || k <= rst_at);
      e_addr   = a; e_size = sz; e_strobe = sb; e_data = wd;
      e_err    = x_err;
      e_lit_en = 1'b1; e_lit = lit;
      e_zero   = abort && (k > rst_at);
      e_hold   = (k == 0) || (!abort && k > done_c);
      e_hold_val = (k == 0) ? prev_rd : rd;
    end
    prev_rd = abort ? 32'd0 : rd;
  endtask

  initial begin
    // reset block
    @(posedge clk); #1;
    e_zero = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    run_txn(OP_LB,  32'h1003, 32'h0,        32'h8000_0000, 1, 1,  32'hFFFF_FF80, 0, -1);
    run_txn(OP_LBU, 32'h1003, 32'h0,        32'h8000_0000, 1, 1,  32'h0000_0080, 0, -1);
    run_txn(OP_LH,  32'h2002, 32'h0,        32'h8001_1234, 1, 4,  32'hFFFF_8001, 1, -1);
    run_txn(OP_LHU, 32'h2000, 32'h0,        32'h8001_9234, 2, 2,  32'h0000_9234, 0, -1);
    run_txn(OP_SW,  32'h3000, 32'hDEADBEEF, 32'h1234_5678, 3, 3,  32'h0,         0, -1);
    run_txn(OP_LW,  32'h4000, 32'h0,        32'hCAFE_F00D, 1, 2,  32'hCAFE_F00D, 0, -1);
    run_txn(OP_LW,  32'h5000, 32'h0,        32'hAAAA_5555, 20, 12, 32'h0,        0, -1);
    run_txn(OP_LB,  32'h1001, 32'h0,        32'h0000_7F00, 1, 1,  32'h0000_007F, 0, -1);
    run_txn(OP_SB,  32'h6002, 32'h5A5A5A5A, 32'hFFFF_FFFF, 1, 1,  32'h0,         0, -1);
    run_txn(OP_LH,  32'h2002, 32'h0,        32'h8001_1234, 1, 5,  32'h0,         0, 3);
    run_txn(OP_LHU, 32'h7002, 32'h0,        32'hFEDC_0000, 1, 1,  32'h0000_FEDC, 0, -1);

    @(posedge clk); #1;
    start = 1'b0;
    chk_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
